// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32 opcodes,
// PC select encoding and controller state.
package hazard_pkg;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_TARGET = 2'b01,
    PC_HOLD   = 2'b10
  } pcsel_e;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    FREEZE = 2'b10
  } state_e;

  // Control transfer resolved in EX: taken branch or any jump.
  function automatic logic is_redirect(input logic [6:0] opcode, input logic br_en);
    return br_en | (opcode == JAL) | (opcode == JALR);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst)                  q <= '0;
    else if (inc && q != '1)   q <= q + W'(1);
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage RV32 pipeline: redirect bubbles,
// load-use stalls and memory-wait freezes, plus saturating perf counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int EXTRA_FLUSH = 1,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        ex_opcode,
  input  logic              ex_BrEn,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              im_wait,
  input  logic              dm_wait,
  output logic [1:0]        PCSel,
  output logic              pc_we,
  output logic              if_id_we,
  output logic              id_ex_we,
  output logic              ex_mem_we,
  output logic              mem_wb_we,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              branch,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int BW = (EXTRA_FLUSH > 0) ? $clog2(EXTRA_FLUSH + 1) : 1;
  localparam logic [BW-1:0] BCNT_LOAD = BW'(EXTRA_FLUSH);
  localparam logic [BW-1:0] BCNT_RST  = BW'((EXTRA_FLUSH > 0) ? EXTRA_FLUSH : 1);

  state_e          state_q, state_d, eff_state;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  pcsel_e          pcsel;
  logic            freeze, redirect, load_use;
  logic            redirect_inc, stall_inc;

  assign freeze   = im_wait | dm_wait;
  assign redirect = is_redirect(ex_opcode, ex_BrEn);
  assign load_use = (ex_opcode == LOAD) && (ex_rd != '0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  // A non-zero bcnt means the freeze interrupted a bubble window.
  assign eff_state = (state_q == FREEZE) ? ((bcnt_q != '0) ? BUBBLE : RUN) : state_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d      = eff_state;
    bcnt_d       = bcnt_q;
    pcsel        = PC_NEXT;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    id_ex_we     = 1'b1;
    ex_mem_we    = 1'b1;
    mem_wb_we    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    branch       = 1'b0;
    redirect_inc = 1'b0;
    stall_inc    = 1'b0;

    if (freeze) begin
      pcsel     = PC_HOLD;
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
      state_d   = FREEZE;
      stall_inc = 1'b1;
    end else if (redirect) begin
      pcsel        = PC_TARGET;
      branch       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      redirect_inc = 1'b1;
      bcnt_d       = BCNT_LOAD;
      state_d      = (EXTRA_FLUSH > 0) ? BUBBLE : RUN;
    end else if (eff_state == BUBBLE) begin
      // The ID instruction is squashed anyway, so load-use is moot here.
      id_ex_flush = 1'b1;
      bcnt_d      = bcnt_q - BW'(1);
      if (bcnt_q == BW'(1)) state_d = RUN;
    end else if (load_use) begin
      pcsel       = PC_HOLD;
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_flush = 1'b1;
      stall_inc   = 1'b1;
    end

    if (!rst) begin
      pcsel        = PC_HOLD;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      branch       = 1'b0;
      redirect_inc = 1'b0;
      stall_inc    = 1'b0;
    end
  end

  assign PCSel = pcsel;

  // Reset parks in BUBBLE so the first cycle after release squashes ID/EX.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment to avoid update races.
    if (!rst) begin
      state_q <= BUBBLE;
      bcnt_q  <= BCNT_RST;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect_inc),
    .q   (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (EXTRA_FLUSH=1/CNT_W=32 and
// EXTRA_FLUSH=3/CNT_W=4) share stimulus and are checked against a window model.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] ex_opcode;
  logic       ex_BrEn;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2, im_wait, dm_wait;

  logic [1:0]  pcsel_o [2];
  logic        pc_we_o [2], if_id_we_o [2], id_ex_we_o [2], ex_mem_we_o [2], mem_wb_we_o [2];
  logic        if_id_fl_o [2], id_ex_fl_o [2], branch_o [2];
  logic [31:0] red_a, stall_a;
  logic [3:0]  red_b, stall_b;
  logic [63:0] red_o [2], stall_o [2];

  assign red_o[0]   = 64'(red_a);
  assign red_o[1]   = 64'(red_b);
  assign stall_o[0] = 64'(stall_a);
  assign stall_o[1] = 64'(stall_b);

  hazard_ctrl_unit #(.EXTRA_FLUSH(1), .REG_AW(5), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .ex_opcode(ex_opcode), .ex_BrEn(ex_BrEn), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .im_wait(im_wait), .dm_wait(dm_wait), .PCSel(pcsel_o[0]), .pc_we(pc_we_o[0]),
    .if_id_we(if_id_we_o[0]), .id_ex_we(id_ex_we_o[0]), .ex_mem_we(ex_mem_we_o[0]),
    .mem_wb_we(mem_wb_we_o[0]), .if_id_flush(if_id_fl_o[0]), .id_ex_flush(id_ex_fl_o[0]),
    .branch(branch_o[0]), .redirect_cnt(red_a), .stall_cnt(stall_a));

  hazard_ctrl_unit #(.EXTRA_FLUSH(3), .REG_AW(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .ex_opcode(ex_opcode), .ex_BrEn(ex_BrEn), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .im_wait(im_wait), .dm_wait(dm_wait), .PCSel(pcsel_o[1]), .pc_we(pc_we_o[1]),
    .if_id_we(if_id_we_o[1]), .id_ex_we(id_ex_we_o[1]), .ex_mem_we(ex_mem_we_o[1]),
    .mem_wb_we(mem_wb_we_o[1]), .if_id_flush(if_id_fl_o[1]), .id_ex_flush(id_ex_fl_o[1]),
    .branch(branch_o[1]), .redirect_cnt(red_b), .stall_cnt(stall_b));

  // Model: u counts live (unreset, unfrozen) cycles; a bubble is any live
  // cycle whose index is <= bend, the end of the current window.
  int     n_tests = 0;
  int     n_fail  = 0;
  int     ef [2]   = '{1, 3};
  longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
  longint m_red [2], m_stall [2];
  int     u [2], bend [2];
  bit     model_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat_inc(input longint v, input longint mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic set_nop();
    rst = 1'b1; ex_opcode = 7'b0010011; ex_BrEn = 1'b0; ex_rd = 5'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    im_wait = 1'b0; dm_wait = 1'b0;
  endtask

  // Inputs are set just after a falling edge; sample, clock, update model.
  task automatic tick();
    logic       redir, lu, frz, bub, e_br;
    logic [1:0] e_pc, e_fl;
    logic [4:0] e_we;
    #1;
    redir = ex_BrEn || ex_opcode == JAL || ex_opcode == JALR;
    lu    = ex_opcode == LOAD && ex_rd != 0 &&
            ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    frz   = im_wait || dm_wait;
    for (int d = 0; d < 2; d++) begin
      bub  = (u[d] <= bend[d]);
      e_pc = PC_NEXT; e_we = 5'b11111; e_fl = 2'b00; e_br = 1'b0;
      if (!rst)       begin e_pc = PC_HOLD; e_we = 5'b00000; e_fl = 2'b11; end
      else if (frz)   begin e_pc = PC_HOLD; e_we = 5'b00000; end
      else if (redir) begin e_pc = PC_TARGET; e_fl = 2'b11; e_br = 1'b1; end
      else if (bub)   e_fl = 2'b01;
      else if (lu)    begin e_pc = PC_HOLD; e_we = 5'b00111; e_fl = 2'b01; end
      check($sformatf("pcsel[%0d]", d), 64'(pcsel_o[d]), 64'(e_pc));
      check($sformatf("we[%0d]", d),
            64'({pc_we_o[d], if_id_we_o[d], id_ex_we_o[d], ex_mem_we_o[d], mem_wb_we_o[d]}),
            64'(e_we));
      check($sformatf("flush[%0d]", d), 64'({if_id_fl_o[d], id_ex_fl_o[d]}), 64'(e_fl));
      check($sformatf("branch[%0d]", d), 64'(branch_o[d]), 64'(e_br));
      if (model_valid) begin
        check($sformatf("redirect_cnt[%0d]", d), red_o[d], m_red[d]);
        check($sformatf("stall_cnt[%0d]", d), stall_o[d], m_stall[d]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      bub = (u[d] <= bend[d]);
      if (!rst) begin
        m_red[d]   = 0;
        m_stall[d] = 0;
        bend[d]    = u[d] + ((ef[d] > 0) ? ef[d] : 1) - 1;
      end else if (frz) begin
        m_stall[d] = sat_inc(m_stall[d], cmax[d]);
      end else begin
        if (redir) begin
          m_red[d] = sat_inc(m_red[d], cmax[d]);
          bend[d]  = u[d] + ef[d];
        end else if (!bub && lu) begin
          m_stall[d] = sat_inc(m_stall[d], cmax[d]);
        end
        u[d]++;
      end
    end
    if (!rst) model_valid = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    u = '{0, 0}; bend = '{0, 0}; m_red = '{0, 0}; m_stall = '{0, 0};
    set_nop();
    @(negedge clk);

    // Reset held three cycles, then release into the bubble window.
    set_nop(); rst = 1'b0;
    repeat (3) tick();
    set_nop();
    repeat (4) tick();

    // Taken branch.
    ex_BrEn = 1'b1; tick();
    set_nop(); repeat (4) tick();

    // Load-use on rs2, then the same pattern with x0 as destination.
    ex_opcode = LOAD; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; tick();
    set_nop(); tick();
    ex_opcode = LOAD; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1; tick();
    set_nop(); tick();

    // Data-memory wait for four cycles with JALR held in EX.
    ex_opcode = JALR; dm_wait = 1'b1; repeat (4) tick();
    dm_wait = 1'b0; tick();
    set_nop(); repeat (4) tick();

    // Redirect together with a matching load-use pattern.
    ex_BrEn = 1'b1; ex_opcode = LOAD; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; tick();
    set_nop(); repeat (4) tick();

    // Second redirect inside the window reloads it.
    ex_BrEn = 1'b1; tick();
    set_nop(); tick();
    ex_BrEn = 1'b1; tick();
    set_nop(); repeat (5) tick();

    // Reset arriving in the middle of a bubble window.
    ex_BrEn = 1'b1; tick();
    set_nop(); rst = 1'b0; tick();
    set_nop(); repeat (4) tick();

    // Counter saturation: 20 back-to-back redirects from a fresh reset.
    set_nop(); rst = 1'b0; tick();
    set_nop(); repeat (4) tick();
    for (int i = 0; i < 20; i++) begin
      set_nop(); ex_opcode = JAL; tick();
    end
    check("redirect_sat_b", 64'(red_b), 64'd15);
    check("redirect_cnt_a", 64'(red_a), 64'd20);
    set_nop(); repeat (4) tick();

    // Randomised traffic with small register range to provoke matches.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] ops [5];
      ops = '{LOAD, JAL, JALR, BRANCH, 7'b0110011};
      rst        = ($urandom_range(0, 59) != 0);
      ex_opcode  = ops[$urandom_range(0, 4)];
      ex_BrEn    = (ex_opcode == BRANCH) && ($urandom_range(0, 2) == 0);
      ex_rd      = 5'($urandom_range(0, 7));
      id_rs1     = 5'($urandom_range(0, 7));
      id_rs2     = 5'($urandom_range(0, 7));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      im_wait    = ($urandom_range(0, 9) == 0);
      dm_wait    = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
